// File: rtl/vga_glyph_colorizer_pkg.sv
// Shared definitions for the VGA glyph colouriser.
// Holds the letter codes, mode encodings, the effect FSM state type,
// the per-theme palettes and the 16-segment A-Z font table.
package vga_glyph_pkg;

    localparam int FONT_W = 16;
    localparam int PAL_W  = 12;

    // Letter codes as presented by the text/game controller
    typedef enum logic [4:0] {
        L_A, L_B, L_C, L_D, L_E, L_F, L_G, L_H, L_I, L_J, L_K, L_L, L_M,
        L_N, L_O, L_P, L_Q, L_R, L_S, L_T, L_U, L_V, L_W, L_X, L_Y, L_Z,
        L_BLANK = 5'd31
    } letter_e;

    typedef enum logic [1:0] {
        MODE_STEADY = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CYCLE  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_STEADY,
        S_BLINK_FG,
        S_BLINK_ALT,
        S_CYCLE,
        S_OFF
    } state_e;

    // Theme 3 is the monochrome theme on which all effects are suppressed
    localparam logic [1:0] THEME_MONO = 2'd3;

    typedef struct packed {
        logic [PAL_W-1:0] bg;
        logic [PAL_W-1:0] fg;
        logic [PAL_W-1:0] alt;
    } palette_t;

    function automatic palette_t theme_palette(input logic [1:0] theme);
        palette_t p;
        case (theme)
            2'd0:    begin p.bg = 12'h000; p.fg = 12'hfff; p.alt = 12'hf00; end
            2'd1:    begin p.bg = 12'hfff; p.fg = 12'h000; p.alt = 12'hf00; end
            2'd2:    begin p.bg = 12'he7d; p.fg = 12'hfff; p.alt = 12'h8f0; end
            default: begin p.bg = 12'h000; p.fg = 12'hfff; p.alt = 12'hfff; end
        endcase
        return p;
    endfunction

    // Segment bit i lit for the given letter; codes above Z are blank
    function automatic logic [FONT_W-1:0] font_mask(input logic [4:0] letter);
        logic [FONT_W-1:0] m;
        case (letter)
            5'd0:    m = 16'hC3E7;
            5'd1:    m = 16'hC0CF;
            5'd2:    m = 16'h0039;
            5'd3:    m = 16'hC00F;
            5'd4:    m = 16'h00F9;
            5'd5:    m = 16'h00F1;
            5'd6:    m = 16'h02BD;
            5'd7:    m = 16'h03F6;
            5'd8:    m = 16'hC009;
            5'd9:    m = 16'h001E;
            5'd10:   m = 16'h2870;
            5'd11:   m = 16'h0038;
            5'd12:   m = 16'h0C36;
            5'd13:   m = 16'h2436;
            5'd14:   m = 16'h003F;
            5'd15:   m = 16'h03F3;
            5'd16:   m = 16'h203F;
            5'd17:   m = 16'h23F3;
            5'd18:   m = 16'h03ED;
            5'd19:   m = 16'hC001;
            5'd20:   m = 16'h003E;
            5'd21:   m = 16'h1830;
            5'd22:   m = 16'h3036;
            5'd23:   m = 16'h3C00;
            5'd24:   m = 16'h4C00;
            5'd25:   m = 16'h1809;
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/vga_glyph_colorizer_if.sv
// Controller-to-colouriser bus: load/effect strobes in, mask and colours out.
interface vga_glyph_colorizer_if #(
    parameter int SEG_N   = 16,
    parameter int COLOR_W = 12
);
    logic                     valid;
    logic [4:0]               letter;
    logic [1:0]               theme;
    logic [1:0]               mode;
    logic                     tick;
    logic [SEG_N-1:0]         glyph_mask;
    logic [SEG_N*COLOR_W-1:0] seg_color;
    logic [COLOR_W-1:0]       fg_color;

    modport master (
        output valid, letter, theme, mode, tick,
        input  glyph_mask, seg_color, fg_color
    );

    modport slave (
        input  valid, letter, theme, mode, tick,
        output glyph_mask, seg_color, fg_color
    );
endinterface

// File: rtl/vga_glyph_colorizer_font.sv
// Combinational letter-to-segment ROM. Segments beyond the 16-segment
// font read unlit; a narrower SEG_N simply drops the upper segments.
module vga_glyph_font
    import vga_glyph_pkg::*;
#(
    parameter int SEG_N = 16
) (
    input  logic [4:0]       letter,
    output logic [SEG_N-1:0] mask
);
    localparam int N_FONT = (SEG_N < FONT_W) ? SEG_N : FONT_W;

    logic [FONT_W-1:0] full;

    assign full = font_mask(letter);

    // Copy the defined font bits, leave any extra segments dark
    always_comb begin
        mask = '0;
        for (int i = 0; i < N_FONT; i++) begin
            mask[i] = full[i];
        end
    end
endmodule

// File: rtl/vga_glyph_colorizer.sv
// VGA glyph colouriser: decodes a letter through the segment font and
// colours each segment from the selected theme palette, with a registered
// steady/blink/colour-cycle/off effect FSM stepped by an external tick.
// Optional feature macro: VGA_GLYPH_CYCLE_EN enables the colour-cycle
// effect; without it mode 2 behaves as steady.
module vga_glyph_colorizer
    import vga_glyph_pkg::*;
#(
    parameter int SEG_N       = 16,
    parameter int COLOR_W     = 12,
    parameter int BLINK_TICKS = 8,
    parameter int CYCLE_STEP  = 1
) (
    input logic                  clk,
    input logic                  rst,
    vga_glyph_colorizer_if.slave bus
);
    localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_TICKS - 1);

    logic [4:0]         letter_q;
    logic [1:0]         theme_q;
    logic [1:0]         mode_q;
    logic [SEG_N-1:0]   mask_q;
    logic [4:0]         font_in;
    logic [SEG_N-1:0]   font_out;

    state_e             state_q, state_d;
    logic [COLOR_W-1:0] fg_q, fg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    palette_t           pal_new;
    palette_t           pal_cur;
    logic [COLOR_W-1:0] bg;
    logic [SEG_N-1:0]   glyph_mask;
    logic [SEG_N*COLOR_W-1:0] seg_color;

    // Theme 3 suppresses all effects; without the cycle option mode 2 is steady
    function automatic state_e entry_state(input logic [1:0] th, input logic [1:0] md);
        state_e s;
        s = S_STEADY;
        if (th != THEME_MONO) begin
            case (mode_e'(md))
                MODE_BLINK: s = S_BLINK_FG;
`ifdef VGA_GLYPH_CYCLE_EN
                MODE_CYCLE: s = S_CYCLE;
`endif
                MODE_OFF:   s = S_OFF;
                default:    s = S_STEADY;
            endcase
        end
        return s;
    endfunction

    // Decode the incoming letter on a load, otherwise keep the latched one
    assign font_in = bus.valid ? bus.letter : letter_q;

    vga_glyph_font #(.SEG_N(SEG_N)) u_font (
        .letter (font_in),
        .mask   (font_out)
    );

    assign pal_new = theme_palette(bus.theme);
    assign pal_cur = theme_palette(theme_q);
    assign bg      = COLOR_W'(pal_cur.bg);

    // Latch letter/theme/mode on load and register the decoded font mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            letter_q <= L_BLANK;
            theme_q  <= 2'd0;
            mode_q   <= 2'd0;
            mask_q   <= '0;
        end else begin
            if (bus.valid) begin
                letter_q <= bus.letter;
                theme_q  <= bus.theme;
                mode_q   <= bus.mode;
            end
            mask_q <= font_out;
        end
    end

    // Effect state, foreground colour and blink tick counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_STEADY;
            fg_q    <= COLOR_W'(12'hfff);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            fg_q    <= fg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next effect state: a load with a new theme/mode restarts the effect and
    // swallows any coincident tick; otherwise ticks advance blink or cycle
    always_comb begin
        state_d = state_q;
        fg_d    = fg_q;
        cnt_d   = cnt_q;
        if (bus.valid) begin
            if (bus.theme != theme_q || bus.mode != mode_q) begin
                fg_d    = COLOR_W'(pal_new.fg);
                cnt_d   = '0;
                state_d = entry_state(bus.theme, bus.mode);
            end
        end else if (bus.tick) begin
            case (state_q)
                S_BLINK_FG, S_BLINK_ALT: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (state_q == S_BLINK_FG) begin
                            state_d = S_BLINK_ALT;
                            fg_d    = COLOR_W'(pal_cur.alt);
                        end else begin
                            state_d = S_BLINK_FG;
                            fg_d    = COLOR_W'(pal_cur.fg);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef VGA_GLYPH_CYCLE_EN
                S_CYCLE: begin
                    fg_d = fg_q + COLOR_W'(CYCLE_STEP);
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign glyph_mask = (state_q == S_OFF) ? '0 : mask_q;

    // Per-segment colour mux: lit segments take fg, dark ones the theme bg
    always_comb begin
        seg_color = '0;
        for (int i = 0; i < SEG_N; i++) begin
            seg_color[i*COLOR_W +: COLOR_W] = glyph_mask[i] ? fg_q : bg;
        end
    end

    assign bus.glyph_mask = glyph_mask;
    assign bus.seg_color  = seg_color;
    assign bus.fg_color   = fg_q;

endmodule

// File: tb/tb_vga_glyph_colorizer.sv
// Self-checking bench for vga_glyph_colorizer: directed scenarios followed by
// randomized loads and ticks, compared against a behavioural reference model.
module tb_vga_glyph_colorizer;

    localparam int SEG_N   = 16;
    localparam int COLOR_W = 12;
    localparam int BLINK   = 2;
    localparam int VEC_W   = SEG_N * COLOR_W;

    logic clk;
    logic rst;

    int checkCount;
    int failCount;

    vga_glyph_colorizer_if #(.SEG_N(SEG_N), .COLOR_W(COLOR_W)) bus ();

    vga_glyph_colorizer #(
        .SEG_N       (SEG_N),
        .COLOR_W     (COLOR_W),
        .BLINK_TICKS (BLINK),
        .CYCLE_STEP  (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tables
    logic [15:0] fontRom [26];
    logic [11:0] palBg  [4];
    logic [11:0] palFg  [4];
    logic [11:0] palAlt [4];

    // Reference model state
    int          mLetter;
    int          mTheme;
    int          mMode;
    int          mEff;
    int          mTicks;
    bit          mAlt;
    logic [11:0] mFg;

    initial begin
        fontRom = '{16'hC3E7, 16'hC0CF, 16'h0039, 16'hC00F, 16'h00F9, 16'h00F1,
                    16'h02BD, 16'h03F6, 16'hC009, 16'h001E, 16'h2870, 16'h0038,
                    16'h0C36, 16'h2436, 16'h003F, 16'h03F3, 16'h203F, 16'h23F3,
                    16'h03ED, 16'hC001, 16'h003E, 16'h1830, 16'h3036, 16'h3C00,
                    16'h4C00, 16'h1809};
        palBg  = '{12'h000, 12'hfff, 12'he7d, 12'h000};
        palFg  = '{12'hfff, 12'h000, 12'hfff, 12'hfff};
        palAlt = '{12'hf00, 12'hf00, 12'h8f0, 12'hfff};
    end

    task automatic modelReset();
        mLetter = 31;
        mTheme  = 0;
        mMode   = 0;
        mEff    = 0;
        mTicks  = 0;
        mAlt    = 0;
        mFg     = 12'hfff;
    endtask

    // Behaviour actually in force for a theme/mode pair
    function automatic int effectiveMode(input int th, input int md);
        if (th == 3) return 0;
`ifndef VGA_GLYPH_CYCLE_EN
        if (md == 2) return 0;
`endif
        return md;
    endfunction

    task automatic modelStep(input bit v, input int l, input int th, input int md, input bit tk);
        if (v) begin
            if (th != mTheme || md != mMode) begin
                mFg    = palFg[th];
                mTicks = 0;
                mAlt   = 0;
                mEff   = effectiveMode(th, md);
            end
            mLetter = l;
            mTheme  = th;
            mMode   = md;
        end else if (tk) begin
            if (mEff == 1) begin
                mTicks++;
                if (mTicks == BLINK) begin
                    mTicks = 0;
                    mAlt   = !mAlt;
                    mFg    = mAlt ? palAlt[mTheme] : palFg[mTheme];
                end
            end else if (mEff == 2) begin
                mFg = mFg + 12'd1;
            end
        end
    endtask

    function automatic logic [15:0] expMask();
        if (mEff == 3 || mLetter > 25) return 16'h0000;
        return fontRom[mLetter];
    endfunction

    function automatic logic [VEC_W-1:0] expSeg();
        logic [VEC_W-1:0] r;
        logic [15:0]      m;
        m = expMask();
        r = '0;
        for (int i = 0; i < SEG_N; i++) begin
            r[i*COLOR_W +: COLOR_W] = m[i] ? mFg : palBg[mTheme];
        end
        return r;
    endfunction

    function automatic logic [VEC_W-1:0] fillAll(input logic [11:0] c);
        logic [VEC_W-1:0] r;
        for (int i = 0; i < SEG_N; i++) r[i*COLOR_W +: COLOR_W] = c;
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        checkCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic compareModel(input string tag);
        checkOutput({tag, ".mask"}, VEC_W'(bus.glyph_mask), VEC_W'(expMask()));
        checkOutput({tag, ".fg"},   VEC_W'(bus.fg_color),   VEC_W'(mFg));
        checkOutput({tag, ".seg"},  bus.seg_color,          expSeg());
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare to the model
    task automatic applyStimulus(input bit v, input int l, input int th, input int md,
                                 input bit tk, input string tag);
        @(negedge clk);
        bus.valid  = v;
        bus.letter = 5'(l);
        bus.theme  = 2'(th);
        bus.mode   = 2'(md);
        bus.tick   = tk;
        @(posedge clk);
        #1;
        modelStep(v, l, th, md, tk);
        compareModel(tag);
    endtask

    logic [11:0] blinkExp [4];

    initial begin
        bit v;
        bit tk;
        int th;
        int md;

        checkCount = 0;
        failCount  = 0;
        blinkExp   = '{12'hfff, 12'hf00, 12'hf00, 12'hfff};
        rst        = 1'b1;
        bus.valid  = 1'b0;
        bus.letter = 5'd0;
        bus.theme  = 2'd0;
        bus.mode   = 2'd0;
        bus.tick   = 1'b0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset.mask", VEC_W'(bus.glyph_mask), '0);
        checkOutput("reset.seg",  bus.seg_color, '0);
        checkOutput("reset.fg",   VEC_W'(bus.fg_color), VEC_W'(12'hfff));
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] letter A, theme 0, steady");
        applyStimulus(1, 0, 0, 0, 0, "letterA");
        checkOutput("letterA.maskConst", VEC_W'(bus.glyph_mask), VEC_W'(16'hC3E7));

        $display("[TB] letter T, theme 1, steady");
        applyStimulus(1, 19, 1, 0, 0, "letterT");
        checkOutput("letterT.maskConst", VEC_W'(bus.glyph_mask), VEC_W'(16'hC001));
        checkOutput("letterT.fgConst",   VEC_W'(bus.fg_color),   VEC_W'(12'h000));

        $display("[TB] blink on theme 0");
        applyStimulus(1, 0, 0, 1, 0, "blinkLoad");
        for (int k = 0; k < 4; k++) begin
            applyStimulus(0, 0, 0, 1, 1, "blinkTick");
            checkOutput("blinkTick.fgConst", VEC_W'(bus.fg_color), VEC_W'(blinkExp[k]));
        end

        $display("[TB] load coincident with tick mid-blink");
        applyStimulus(0, 0, 0, 1, 1, "midTick");
        applyStimulus(1, 2, 0, 1, 1, "coincident");
        checkOutput("coincident.fgConst", VEC_W'(bus.fg_color), VEC_W'(12'hfff));
        applyStimulus(0, 0, 0, 1, 1, "afterCoincident");
        checkOutput("afterCoincident.fgConst", VEC_W'(bus.fg_color), VEC_W'(12'hf00));

        $display("[TB] colour cycle wrap");
        applyStimulus(1, 0, 0, 2, 0, "cycleLoad");
        applyStimulus(0, 0, 0, 2, 1, "cycleTick");
`ifdef VGA_GLYPH_CYCLE_EN
        checkOutput("cycleTick.fgConst", VEC_W'(bus.fg_color), VEC_W'(12'h000));
`else
        checkOutput("cycleTick.fgConst", VEC_W'(bus.fg_color), VEC_W'(12'hfff));
`endif

        $display("[TB] blank letter and off mode");
        applyStimulus(1, 30, 2, 3, 0, "offBlank");
        checkOutput("offBlank.segConst", bus.seg_color, fillAll(12'he7d));

        $display("[TB] asynchronous reset mid-cycle");
        applyStimulus(1, 5, 0, 2, 0, "preReset");
        applyStimulus(0, 5, 0, 2, 1, "preResetTick");
        @(negedge clk);
        bus.valid = 1'b0;
        bus.tick  = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        modelReset();
        checkOutput("asyncReset.seg",  bus.seg_color, '0);
        checkOutput("asyncReset.mask", VEC_W'(bus.glyph_mask), '0);
        checkOutput("asyncReset.fg",   VEC_W'(bus.fg_color), VEC_W'(12'hfff));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] randomized loads and ticks");
        for (int n = 0; n < 400; n++) begin
            v  = ($urandom_range(0, 3) == 0);
            tk = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 0) begin
                th = mTheme;
                md = mMode;
            end else begin
                th = int'($urandom_range(0, 3));
                md = int'($urandom_range(0, 3));
            end
            applyStimulus(v, int'($urandom_range(0, 31)), th, md, tk, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
